spike_event_logger: RTL and testbench

Timestamps spike onsets from the two Hodgkin–Huxley neurons (pre- and post-synaptic `spike` outputs) and buffers them in a small FIFO. The FIFO drains through a valid/ready port, so a host or serialiser can reconstruct spike rasters and STDP timing off-chip. The block sits directly downstream of the neuron/synapse pair and consumes its level-type spike flags, which stay high for as long as `v_mem > 0`.

---
 rtl/spike_event_logger.sv | 158 +++++++++++++++
 tb/tb_spike_event_logger.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_logger.sv
`default_nettype none
// ============================================================================
//  Module      : spike_event_logger
//  Description : Timestamps spike onsets from two neurons and queues them in a
//                first-word fall-through FIFO drained over valid/ready.
//                Optional ts-wrap marker entries: SPIKE_LOG_WRAP_MARK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_event_logger #(
    parameter int TS_WIDTH = 14,
    parameter int DEPTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ena,
    input  logic                    clear,
    input  logic                    spike_a,
    input  logic                    spike_b,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [TS_WIDTH+1:0]     out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [7:0]              drop_count
);

    localparam int         c_addr_w     = $clog2(DEPTH);
    localparam int         c_ptr_w      = c_addr_w + 1;
    localparam logic [7:0] c_presc_last = 8'(PRESCALE - 1);

    logic                    r_prev_a;
    logic                    r_prev_b;
    logic [7:0]              r_presc;
    logic [TS_WIDTH-1:0]     r_ts;
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [TS_WIDTH+1:0]     r_mem [DEPTH];
    logic                    r_overflow;
    logic [7:0]              r_drop_count;

    logic                    w_onset_a;
    logic                    w_onset_b;
    logic                    w_tick;
    logic                    w_spike_evt;
    logic                    w_marker;
    logic                    w_push;
    logic [TS_WIDTH+1:0]     w_push_data;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;
    logic                    w_drop;

    assign w_onset_a   = spike_a & ~r_prev_a;
    assign w_onset_b   = spike_b & ~r_prev_b;
    assign w_tick      = ena & (r_presc == c_presc_last);
    assign w_spike_evt = ena & (w_onset_a | w_onset_b);

`ifdef SPIKE_LOG_WRAP_MARK_EN
    logic r_wrap_pend;
    logic w_wrap;

    assign w_wrap   = w_tick & (r_ts == {TS_WIDTH{1'b1}});
    // Markers only fill otherwise idle enabled edges; spikes always win.
    assign w_marker = ena & r_wrap_pend & ~w_spike_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrap_pend <= 1'b0;
        end else if (clear) begin
            r_wrap_pend <= 1'b0;
        end else begin
            r_wrap_pend <= w_wrap | (r_wrap_pend & ~w_marker);
        end
    end
`else
    assign w_marker = 1'b0;
`endif

    assign w_push      = w_spike_evt | w_marker;
    assign w_push_data = w_spike_evt ? {w_onset_b, w_onset_a, r_ts} : {2'b00, r_ts};

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                       (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_pop     = ~w_empty & out_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    assign out_valid  = ~w_empty;
    assign out_data   = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign level      = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // Edge history loads every cycle, including clear and disabled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_a <= 1'b0;
            r_prev_b <= 1'b0;
        end else begin
            r_prev_a <= spike_a;
            r_prev_b <= spike_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= 8'd0;
            r_ts    <= '0;
        end else if (clear) begin
            r_presc <= 8'd0;
            r_ts    <= '0;
        end else if (w_tick) begin
            r_presc <= 8'd0;
            r_ts    <= r_ts + TS_WIDTH'(1);
        end else if (ena) begin
            r_presc <= r_presc + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !clear) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= w_push_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_event_logger.sv
`default_nettype none
// Bench for spike_event_logger: default-configured instance driven from a
// vector table, plus a TS_WIDTH=4/PRESCALE=4 instance for prescale and wrap.
module tb_spike_event_logger;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic        a_ena, a_clear, a_sa, a_sb, a_rdy;
    logic        a_valid, a_ovf;
    logic [15:0] a_data;
    logic [3:0]  a_level;
    logic [7:0]  a_drop;

    logic        b_ena, b_clear, b_sa, b_sb, b_rdy;
    logic        b_valid, b_ovf;
    logic [5:0]  b_data;
    logic [3:0]  b_level;
    logic [7:0]  b_drop;

    spike_event_logger dut_a (
        .clk(clk), .reset_n(reset_n), .ena(a_ena), .clear(a_clear),
        .spike_a(a_sa), .spike_b(a_sb), .out_ready(a_rdy),
        .out_valid(a_valid), .out_data(a_data), .level(a_level),
        .overflow(a_ovf), .drop_count(a_drop)
    );

    spike_event_logger #(.TS_WIDTH(4), .DEPTH(8), .PRESCALE(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .ena(b_ena), .clear(b_clear),
        .spike_a(b_sa), .spike_b(b_sb), .out_ready(b_rdy),
        .out_valid(b_valid), .out_data(b_data), .level(b_level),
        .overflow(b_ovf), .drop_count(b_drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc_a(input logic en, input logic sa, input logic sb, input logic rdy, input logic clr);
        a_ena = en; a_sa = sa; a_sb = sb; a_rdy = rdy; a_clear = clr;
        @(posedge clk); #1;
    endtask

    task automatic cyc_b(input logic en, input logic sa, input logic sb, input logic rdy, input logic clr);
        b_ena = en; b_sa = sa; b_sb = sb; b_rdy = rdy; b_clear = clr;
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          reps;
        logic        ena, sa, sb, rdy, clr;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [3:0]  exp_level;
        logic        exp_ovf;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] q [$];
    int          ts_a;

    initial begin
        // reps, ena, sa, sb, rdy, clr, valid, data, level, ovf, drop
        vecs[0] = '{10, 1, 0, 0, 0, 0, 0, 16'h0000, 4'd0, 0, 8'd0};
        vecs[1] = '{ 1, 1, 1, 0, 0, 0, 1, 16'h400A, 4'd1, 0, 8'd0};
        vecs[2] = '{ 4, 1, 1, 0, 0, 0, 1, 16'h400A, 4'd1, 0, 8'd0};
        vecs[3] = '{ 1, 1, 0, 0, 1, 0, 0, 16'h0000, 4'd0, 0, 8'd0};
        vecs[4] = '{21, 1, 0, 0, 0, 0, 0, 16'h0000, 4'd0, 0, 8'd0};
        vecs[5] = '{ 1, 1, 1, 1, 0, 0, 1, 16'hC025, 4'd1, 0, 8'd0};
        vecs[6] = '{ 1, 1, 0, 0, 0, 0, 1, 16'hC025, 4'd1, 0, 8'd0};
        vecs[7] = '{ 1, 1, 0, 0, 1, 0, 0, 16'h0000, 4'd0, 0, 8'd0};

        reset_n = 1'b0;
        a_ena = 0; a_clear = 0; a_sa = 0; a_sb = 0; a_rdy = 0;
        b_ena = 0; b_clear = 0; b_sa = 0; b_sb = 0; b_rdy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_valid", a_valid, 0);
        check("rst_level", a_level, 0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_drop",  a_drop,  0);

        // Single onset at ts=10, then coincidence at ts=37.
        for (int i = 0; i < 8; i++) begin
            repeat (vecs[i].reps)
                cyc_a(vecs[i].ena, vecs[i].sa, vecs[i].sb, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d_valid", i), a_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_data", i), a_data, vecs[i].exp_data);
            check($sformatf("vec%0d_level", i), a_level, vecs[i].exp_level);
            check($sformatf("vec%0d_ovf", i),   a_ovf,   vecs[i].exp_ovf);
            check($sformatf("vec%0d_drop", i),  a_drop,  vecs[i].exp_drop);
        end

        // Overflow: ten onsets with the consumer stalled.
        ts_a = 40;
        for (int i = 0; i < 10; i++) begin
            if (q.size() < 8) q.push_back({2'b01, ts_a[13:0]});
            cyc_a(1, 1, 0, 0, 0); ts_a++;
            check($sformatf("ovf_level%0d", i), a_level, q.size());
            cyc_a(1, 0, 0, 0, 0); ts_a++;
        end
        check("ovf_flag", a_ovf, 1);
        check("ovf_drop", a_drop, 2);
        check("ovf_head", a_data, q[0]);

        // Push and pop on the same edge while full.
        void'(q.pop_front());
        q.push_back({2'b01, ts_a[13:0]});
        cyc_a(1, 1, 0, 1, 0); ts_a++;
        check("pp_level", a_level, 8);
        check("pp_drop",  a_drop,  2);

        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid%0d", i), a_valid, 1);
            check($sformatf("drain_data%0d", i),  a_data,  q[0]);
            void'(q.pop_front());
            cyc_a(1, 0, 0, 1, 0);
        end
        check("drain_empty", a_valid, 0);
        check("drain_ovf",   a_ovf,   1);

        cyc_a(1, 0, 0, 0, 1);
        check("clr_level", a_level, 0);
        check("clr_ovf",   a_ovf,   0);
        check("clr_drop",  a_drop,  0);
        cyc_a(1, 1, 0, 0, 0);
        check("clr_ts_valid", a_valid, 1);
        check("clr_ts_data",  a_data,  16'h4000);

        // Drop counter saturation: 7 more accepted, 258 dropped.
        cyc_a(1, 0, 0, 0, 0);
        for (int i = 0; i < 265; i++) begin
            cyc_a(1, 1, 0, 0, 0);
            cyc_a(1, 0, 0, 0, 0);
        end
        check("sat_drop",  a_drop,  8'hFF);
        check("sat_level", a_level, 8);

        // Asynchronous reset between edges.
        reset_n = 1'b0;
        #2;
        check("arst_valid", a_valid, 0);
        check("arst_level", a_level, 0);
        check("arst_ovf",   a_ovf,   0);
        check("arst_drop",  a_drop,  0);
        @(negedge clk);
        reset_n = 1'b1;
        a_ena = 0; a_sa = 0;
        #1;

        // Prescale=4 and enable gating.
        repeat (5) cyc_b(1, 0, 0, 0, 0);
        cyc_b(1, 1, 0, 0, 0);
        check("ps_valid", b_valid, 1);
        check("ps_data",  b_data,  6'h11);
        cyc_b(1, 0, 0, 1, 0);
        check("ps_pop", b_valid, 0);
        cyc_b(0, 0, 1, 0, 0);
        cyc_b(0, 0, 1, 0, 0);
        repeat (4) cyc_b(0, 0, 0, 0, 0);
        check("en_off_valid", b_valid, 0);
        check("en_off_level", b_level, 0);
        cyc_b(1, 0, 0, 0, 0);
        cyc_b(1, 0, 1, 0, 0);
        check("en_on_valid", b_valid, 1);
        check("en_on_data",  b_data,  6'h22);
        cyc_b(1, 0, 0, 1, 0);
        check("en_on_pop", b_valid, 0);

        // Wrap at 16 ticks; spike takes priority over the marker.
        repeat (54) cyc_b(1, 0, 0, 0, 0);
        check("wrap_idle", b_valid, 0);
        cyc_b(1, 1, 0, 0, 0);
        check("wrap_spk_valid", b_valid, 1);
        check("wrap_spk_data",  b_data,  6'h10);
        cyc_b(1, 0, 0, 0, 0);
`ifdef SPIKE_LOG_WRAP_MARK_EN
        check("wrap_level", b_level, 2);
        check("wrap_head",  b_data,  6'h10);
        cyc_b(0, 0, 0, 1, 0);
        check("mark_valid", b_valid, 1);
        check("mark_data",  b_data,  6'h00);
        cyc_b(0, 0, 0, 1, 0);
`else
        check("wrap_level", b_level, 1);
        check("wrap_head",  b_data,  6'h10);
        cyc_b(0, 0, 0, 1, 0);
`endif
        check("wrap_empty", b_valid, 0);

        cyc_b(0, 0, 0, 0, 1);
        check("bclr_level", b_level, 0);
        check("bclr_ovf",   b_ovf,   0);
        check("bclr_drop",  b_drop,  0);
        repeat (3) cyc_b(1, 0, 0, 0, 0);
        cyc_b(1, 1, 0, 0, 0);
        check("bclr_valid", b_valid, 1);
        check("bclr_data",  b_data,  6'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
